// File: rtl/text_console_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// text_console_ctrl_if : character input handshake and char-RAM write port
// Revision: 1.0
// ----------------------------------------------------------------------------
interface text_console_ctrl_if;
  logic        ch_valid;
  logic [6:0]  ch_data;
  logic        ch_ready;
  logic        cls_req;
  logic        wvram;
  logic [12:0] vram_addr;
  logic [6:0]  vram_data;
  logic [5:0]  cursor_row;
  logic [6:0]  cursor_col;
  logic        busy;

  modport master (
    output ch_valid, ch_data, cls_req,
    input  ch_ready, wvram, vram_addr, vram_data, cursor_row, cursor_col, busy
  );

  modport slave (
    input  ch_valid, ch_data, cls_req,
    output ch_ready, wvram, vram_addr, vram_data, cursor_row, cursor_col, busy
  );
endinterface
`default_nettype wire

// File: rtl/text_console_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// text_console_ctrl : text cursor and character-RAM writer with clear screen
// Revision: 1.0
// ----------------------------------------------------------------------------
module text_console_ctrl #(
  parameter int         COLS  = 80,
  parameter int         ROWS  = 60,
  parameter logic [6:0] BLANK = 7'h20
) (
  input  logic              sys_clk,
  input  logic              clr,
  text_console_ctrl_if.slave bus
);

  localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
  localparam logic [5:0]  LAST_ROW  = 6'(ROWS - 1);
  localparam logic [12:0] LAST_ADDR = 13'(ROWS * COLS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    CLEAR = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        wvram_q, wvram_nxt;
  logic [12:0] addr_q, addr_nxt;
  logic [6:0]  data_q, data_nxt;
  logic [5:0]  row_q, row_nxt;
  logic [6:0]  col_q, col_nxt;
  logic [6:0]  code_q, code_nxt;

  // For the default 80 columns the multiply folds into two shifts and an add.
  function automatic logic [12:0] addr_of(input logic [5:0] r, input logic [6:0] c);
    if (COLS == 80)
      addr_of = ({7'd0, r} << 6) + ({7'd0, r} << 4) + {6'd0, c};
    else
      addr_of = ({7'd0, r} * 13'(COLS)) + {6'd0, c};
  endfunction

  logic       printable, is_newline, is_bs, at_origin;
  logic [5:0] row_inc;
  logic [5:0] bs_row;
  logic [6:0] bs_col;

  assign printable  = (bus.ch_data >= 7'h20) && (bus.ch_data <= 7'h7E);
  assign is_newline = (code_q == 7'h0A) || (code_q == 7'h0D);
  assign is_bs      = (code_q == 7'h08);
  assign at_origin  = (row_q == 6'd0) && (col_q == 7'd0);
  assign row_inc    = (row_q == LAST_ROW) ? 6'd0 : row_q + 6'd1;

  // Backspace target; at the origin it stays put.
  always_comb begin
    bs_row = row_q;
    bs_col = col_q;
    if (col_q != 7'd0) begin
      bs_col = col_q - 7'd1;
    end else if (row_q != 6'd0) begin
      bs_row = row_q - 6'd1;
      bs_col = LAST_COL;
    end
  end

  always_comb begin
    state_nxt = state;
    wvram_nxt = 1'b0;
    addr_nxt  = addr_q;
    data_nxt  = data_q;
    row_nxt   = row_q;
    col_nxt   = col_q;
    code_nxt  = code_q;
    case (state)
      IDLE: begin
        if (bus.cls_req) begin
          state_nxt = CLEAR;
          wvram_nxt = 1'b1;
          addr_nxt  = 13'd0;
          data_nxt  = BLANK;
        end else if (bus.ch_valid) begin
          state_nxt = WRITE;
          code_nxt  = bus.ch_data;
          if (printable) begin
            wvram_nxt = 1'b1;
            addr_nxt  = addr_of(row_q, col_q);
            data_nxt  = bus.ch_data;
          end else if ((bus.ch_data == 7'h08) && !at_origin) begin
            wvram_nxt = 1'b1;
            addr_nxt  = addr_of(bs_row, bs_col);
            data_nxt  = BLANK;
          end
        end
      end
      WRITE: begin
        state_nxt = IDLE;
        if ((code_q >= 7'h20) && (code_q <= 7'h7E)) begin
          if (col_q == LAST_COL) begin
            col_nxt = 7'd0;
            row_nxt = row_inc;
          end else begin
            col_nxt = col_q + 7'd1;
          end
        end else if (is_newline) begin
          col_nxt = 7'd0;
          row_nxt = row_inc;
        end else if (is_bs) begin
          row_nxt = bs_row;
          col_nxt = bs_col;
        end
      end
      CLEAR: begin
        if (addr_q == LAST_ADDR) begin
          state_nxt = IDLE;
          row_nxt   = 6'd0;
          col_nxt   = 7'd0;
        end else begin
          wvram_nxt = 1'b1;
          addr_nxt  = addr_q + 13'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge clr) begin
    if (clr) begin
      state   <= IDLE;
      wvram_q <= 1'b0;
      addr_q  <= 13'd0;
      data_q  <= 7'd0;
      row_q   <= 6'd0;
      col_q   <= 7'd0;
      code_q  <= 7'd0;
    end else begin
      state   <= state_nxt;
      wvram_q <= wvram_nxt;
      addr_q  <= addr_nxt;
      data_q  <= data_nxt;
      row_q   <= row_nxt;
      col_q   <= col_nxt;
      code_q  <= code_nxt;
    end
  end

  assign bus.ch_ready   = (state == IDLE) && !bus.cls_req;
  assign bus.busy       = (state != IDLE);
  assign bus.wvram      = wvram_q;
  assign bus.vram_addr  = addr_q;
  assign bus.vram_data  = data_q;
  assign bus.cursor_row = row_q;
  assign bus.cursor_col = col_q;

endmodule
`default_nettype wire

// File: tb/tb_text_console_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_text_console_ctrl : directed self-checking bench for text_console_ctrl
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_text_console_ctrl;

  logic sys_clk = 1'b0;
  logic clr     = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  text_console_ctrl_if cif();

  text_console_ctrl dut (
    .sys_clk (sys_clk),
    .clr     (clr),
    .bus     (cif.slave)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic reset_dut;
    clr = 1'b1;
    @(posedge sys_clk); #1;
    clr = 1'b0;
  endtask

  // Offers one code, returns what the write port showed in the WRITE cycle.
  task automatic send_char(input logic [6:0] c, output logic w, output logic [12:0] a,
                           output logic [6:0] d);
    int n;
    n = 0;
    while (!cif.ch_ready && n < 10) begin
      @(posedge sys_clk); #1;
      n++;
    end
    if (n == 10) begin
      n_checks++; n_fail++;
      $display("FAIL send_ready: got ch_ready=0 want 1");
    end
    cif.ch_valid = 1'b1;
    cif.ch_data  = c;
    @(posedge sys_clk); #1;
    w = cif.wvram; a = cif.vram_addr; d = cif.vram_data;
    cif.ch_valid = 1'b0;
    @(posedge sys_clk); #1;
  endtask

  task automatic test_reset;
    cif.ch_valid = 1'b0; cif.ch_data = 7'h00; cif.cls_req = 1'b0;
    clr = 1'b1;
    @(posedge sys_clk); #1;
    n_checks++; if (cif.wvram !== 1'b0) begin n_fail++; $display("FAIL reset_wvram: got %0b want 0", cif.wvram); end
    n_checks++; if (cif.vram_addr !== 13'd0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", cif.vram_addr); end
    n_checks++; if (cif.vram_data !== 7'd0) begin n_fail++; $display("FAIL reset_data: got %0h want 0", cif.vram_data); end
    n_checks++; if (cif.cursor_row !== 6'd0 || cif.cursor_col !== 7'd0) begin n_fail++; $display("FAIL reset_cursor: got %0d,%0d want 0,0", cif.cursor_row, cif.cursor_col); end
    n_checks++; if (cif.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", cif.busy); end
    n_checks++; if (cif.ch_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b want 1", cif.ch_ready); end
    cif.cls_req = 1'b1; #1;
    n_checks++; if (cif.ch_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_cls: got %0b want 0", cif.ch_ready); end
    cif.cls_req = 1'b0;
    @(posedge sys_clk); #1;
    clr = 1'b0;
  endtask

  task automatic test_first_char;
    reset_dut();
    cif.ch_valid = 1'b1; cif.ch_data = 7'h41;
    n_checks++; if (cif.ch_ready !== 1'b1) begin n_fail++; $display("FAIL a_ready: got %0b want 1", cif.ch_ready); end
    @(posedge sys_clk); #1;
    cif.ch_valid = 1'b0;
    n_checks++; if (cif.wvram !== 1'b1 || cif.vram_addr !== 13'd0 || cif.vram_data !== 7'h41)
      begin n_fail++; $display("FAIL a_write: got w=%0b a=%0d d=%0h want 1 0 41", cif.wvram, cif.vram_addr, cif.vram_data); end
    n_checks++; if (cif.busy !== 1'b1 || cif.ch_ready !== 1'b0)
      begin n_fail++; $display("FAIL a_busy: got busy=%0b ready=%0b want 1 0", cif.busy, cif.ch_ready); end
    n_checks++; if (cif.cursor_col !== 7'd0) begin n_fail++; $display("FAIL a_cursor_hold: got col %0d want 0", cif.cursor_col); end
    @(posedge sys_clk); #1;
    n_checks++; if (cif.wvram !== 1'b0 || cif.busy !== 1'b0)
      begin n_fail++; $display("FAIL a_idle: got w=%0b busy=%0b want 0 0", cif.wvram, cif.busy); end
    n_checks++; if (cif.cursor_row !== 6'd0 || cif.cursor_col !== 7'd1)
      begin n_fail++; $display("FAIL a_cursor: got %0d,%0d want 0,1", cif.cursor_row, cif.cursor_col); end
  endtask

  task automatic test_wrap;
    logic w; logic [12:0] a; logic [6:0] d;
    reset_dut();
    for (int i = 0; i < 2; i++) send_char(7'h0A, w, a, d);
    for (int i = 0; i < 79; i++) send_char(7'h78, w, a, d);
    n_checks++; if (cif.cursor_row !== 6'd2 || cif.cursor_col !== 7'd79)
      begin n_fail++; $display("FAIL wrap_pre: got %0d,%0d want 2,79", cif.cursor_row, cif.cursor_col); end
    send_char(7'h42, w, a, d);
    n_checks++; if (w !== 1'b1 || a !== 13'd239 || d !== 7'h42)
      begin n_fail++; $display("FAIL wrap_b: got w=%0b a=%0d d=%0h want 1 239 42", w, a, d); end
    n_checks++; if (cif.cursor_row !== 6'd3 || cif.cursor_col !== 7'd0)
      begin n_fail++; $display("FAIL wrap_b_cursor: got %0d,%0d want 3,0", cif.cursor_row, cif.cursor_col); end
    send_char(7'h0D, w, a, d);
    n_checks++; if (w !== 1'b0 || cif.cursor_row !== 6'd4 || cif.cursor_col !== 7'd0)
      begin n_fail++; $display("FAIL cr: got w=%0b cursor %0d,%0d want 0 4,0", w, cif.cursor_row, cif.cursor_col); end
    for (int i = 0; i < 55; i++) send_char(7'h0A, w, a, d);
    for (int i = 0; i < 79; i++) send_char(7'h61, w, a, d);
    send_char(7'h7E, w, a, d);
    n_checks++; if (w !== 1'b1 || a !== 13'd4799 || d !== 7'h7E)
      begin n_fail++; $display("FAIL last_cell: got w=%0b a=%0d d=%0h want 1 4799 7e", w, a, d); end
    n_checks++; if (cif.cursor_row !== 6'd0 || cif.cursor_col !== 7'd0)
      begin n_fail++; $display("FAIL last_cell_cursor: got %0d,%0d want 0,0", cif.cursor_row, cif.cursor_col); end
    for (int i = 0; i < 59; i++) send_char(7'h0A, w, a, d);
    send_char(7'h0A, w, a, d);
    n_checks++; if (cif.cursor_row !== 6'd0 || cif.cursor_col !== 7'd0)
      begin n_fail++; $display("FAIL lf_wrap: got %0d,%0d want 0,0", cif.cursor_row, cif.cursor_col); end
  endtask

  task automatic test_backspace;
    logic w; logic [12:0] a; logic [6:0] d;
    reset_dut();
    for (int i = 0; i < 5; i++) send_char(7'h0A, w, a, d);
    send_char(7'h08, w, a, d);
    n_checks++; if (w !== 1'b1 || a !== 13'd399 || d !== 7'h20)
      begin n_fail++; $display("FAIL bs_row: got w=%0b a=%0d d=%0h want 1 399 20", w, a, d); end
    n_checks++; if (cif.cursor_row !== 6'd4 || cif.cursor_col !== 7'd79)
      begin n_fail++; $display("FAIL bs_row_cursor: got %0d,%0d want 4,79", cif.cursor_row, cif.cursor_col); end
    send_char(7'h08, w, a, d);
    n_checks++; if (w !== 1'b1 || a !== 13'd398 || cif.cursor_col !== 7'd78)
      begin n_fail++; $display("FAIL bs_col: got w=%0b a=%0d col=%0d want 1 398 78", w, a, cif.cursor_col); end
    send_char(7'h7F, w, a, d);
    n_checks++; if (w !== 1'b0 || cif.cursor_row !== 6'd4 || cif.cursor_col !== 7'd78)
      begin n_fail++; $display("FAIL del_ignored: got w=%0b cursor %0d,%0d want 0 4,78", w, cif.cursor_row, cif.cursor_col); end
    send_char(7'h09, w, a, d);
    n_checks++; if (w !== 1'b0 || cif.cursor_col !== 7'd78)
      begin n_fail++; $display("FAIL tab_ignored: got w=%0b col=%0d want 0 78", w, cif.cursor_col); end
    reset_dut();
    send_char(7'h08, w, a, d);
    n_checks++; if (w !== 1'b0 || cif.cursor_row !== 6'd0 || cif.cursor_col !== 7'd0)
      begin n_fail++; $display("FAIL bs_origin: got w=%0b cursor %0d,%0d want 0 0,0", w, cif.cursor_row, cif.cursor_col); end
  endtask

  task automatic test_back_to_back;
    logic [3:0] wv;
    logic [12:0] a0, a2;
    reset_dut();
    cif.ch_valid = 1'b1; cif.ch_data = 7'h43;
    for (int i = 0; i < 4; i++) begin
      @(posedge sys_clk); #1;
      wv[i] = cif.wvram;
      if (i == 0) a0 = cif.vram_addr;
      if (i == 2) a2 = cif.vram_addr;
    end
    cif.ch_valid = 1'b0;
    n_checks++; if (wv !== 4'b0101)
      begin n_fail++; $display("FAIL b2b_strobe: got %b want 0101", wv); end
    n_checks++; if (a0 !== 13'd0 || a2 !== 13'd1)
      begin n_fail++; $display("FAIL b2b_addr: got %0d,%0d want 0,1", a0, a2); end
    n_checks++; if (cif.cursor_col !== 7'd2)
      begin n_fail++; $display("FAIL b2b_cursor: got col %0d want 2", cif.cursor_col); end
  endtask

  task automatic test_clear;
    logic w; logic [12:0] a; logic [6:0] d;
    int writes, bad;
    send_char(7'h0A, w, a, d);
    cif.cls_req = 1'b1; cif.ch_valid = 1'b1; cif.ch_data = 7'h58;
    #1;
    n_checks++; if (cif.ch_ready !== 1'b0) begin n_fail++; $display("FAIL cls_ready: got %0b want 0", cif.ch_ready); end
    @(posedge sys_clk); #1;
    cif.cls_req = 1'b0; cif.ch_valid = 1'b0;
    writes = 0; bad = 0;
    for (int i = 0; i < 5000 && cif.wvram === 1'b1; i++) begin
      if (cif.vram_addr !== 13'(writes) || cif.vram_data !== 7'h20 || cif.busy !== 1'b1) bad++;
      writes++;
      @(posedge sys_clk); #1;
    end
    n_checks++; if (writes != 4800) begin n_fail++; $display("FAIL clear_count: got %0d want 4800", writes); end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL clear_content: got %0d bad writes want 0", bad); end
    n_checks++; if (cif.busy !== 1'b0 || cif.ch_ready !== 1'b1)
      begin n_fail++; $display("FAIL clear_done: got busy=%0b ready=%0b want 0 1", cif.busy, cif.ch_ready); end
    n_checks++; if (cif.cursor_row !== 6'd0 || cif.cursor_col !== 7'd0)
      begin n_fail++; $display("FAIL clear_cursor: got %0d,%0d want 0,0", cif.cursor_row, cif.cursor_col); end
  endtask

  task automatic test_clear_abort;
    logic w; logic [12:0] a; logic [6:0] d;
    int stray;
    send_char(7'h61, w, a, d);
    send_char(7'h62, w, a, d);
    cif.cls_req = 1'b1;
    @(posedge sys_clk); #1;
    cif.cls_req = 1'b0;
    for (int i = 0; i < 100; i++) begin @(posedge sys_clk); #1; end
    n_checks++; if (cif.wvram !== 1'b1 || cif.vram_addr !== 13'd100)
      begin n_fail++; $display("FAIL abort_pre: got w=%0b a=%0d want 1 100", cif.wvram, cif.vram_addr); end
    #2 clr = 1'b1;
    #1;
    n_checks++; if (cif.wvram !== 1'b0 || cif.busy !== 1'b0 || cif.vram_addr !== 13'd0)
      begin n_fail++; $display("FAIL abort_async: got w=%0b busy=%0b a=%0d want 0 0 0", cif.wvram, cif.busy, cif.vram_addr); end
    n_checks++; if (cif.cursor_row !== 6'd0 || cif.cursor_col !== 7'd0)
      begin n_fail++; $display("FAIL abort_cursor: got %0d,%0d want 0,0", cif.cursor_row, cif.cursor_col); end
    @(posedge sys_clk); #1;
    clr = 1'b0;
    stray = 0;
    for (int i = 0; i < 10; i++) begin @(posedge sys_clk); #1; if (cif.wvram !== 1'b0) stray++; end
    n_checks++; if (stray != 0) begin n_fail++; $display("FAIL abort_stray: got %0d writes want 0", stray); end
    send_char(7'h51, w, a, d);
    n_checks++; if (w !== 1'b1 || a !== 13'd0 || d !== 7'h51)
      begin n_fail++; $display("FAIL abort_next: got w=%0b a=%0d d=%0h want 1 0 51", w, a, d); end
  endtask

  initial begin
    cif.ch_valid = 1'b0;
    cif.ch_data  = 7'h00;
    cif.cls_req  = 1'b0;
    test_reset();
    test_first_char();
    test_wrap();
    test_backspace();
    test_back_to_back();
    test_clear();
    test_clear_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/text_console_ctrl.md
TEXT_CONSOLE_CTRL -- requirements
Module: text_console_ctrl

Interface
REQ-001 SHALL have parameter COLS, default 80, characters per row.
REQ-002 SHALL have parameter ROWS, default 60, character rows.
REQ-003 SHALL have parameter BLANK, default 7'h20, code written by clear and backspace.
REQ-004 sys_clk  input  1  single clock; all state updates on its rising edge.
REQ-005 clr  input  1  reset, asynchronous and active-high.
REQ-006 ch_valid  input  1  character offered.
REQ-007 ch_data  input  7  ASCII code offered.
REQ-008 ch_ready  output  1  controller accepts a character this cycle.
REQ-009 cls_req  input  1  clear-screen request, sampled in IDLE only.
REQ-010 wvram  output  1  char RAM write strobe, registered.
REQ-011 vram_addr  output  13  char RAM address, registered.
REQ-012 vram_data  output  7  char RAM write data, registered.
REQ-013 cursor_row  output  6  current cursor row.
REQ-014 cursor_col  output  7  current cursor column.
REQ-015 busy  output  1  high while in WRITE or CLEAR.

Function
REQ-016 SHALL implement three states: IDLE, WRITE, CLEAR.
REQ-017 ch_ready SHALL be 1 only in IDLE with cls_req low; a character is accepted on the cycle ch_valid and ch_ready are both high.
REQ-018 cls_req high in IDLE SHALL take priority over ch_valid: no character is accepted that cycle, and the next state is CLEAR.
REQ-019 A write address SHALL be row*COLS+col, computed as (row<<6)+(row<<4)+col for the default COLS; the result is 13 bits.
REQ-020 Printable codes 7'h20..7'h7E SHALL go to WRITE, asserting wvram for exactly one cycle, the cycle after acceptance, with vram_addr at the cursor position and vram_data equal to ch_data.
REQ-021 After a printable write, the cursor SHALL advance: col+1; at col COLS-1, col wraps to 0 and row increments; at row ROWS-1, row wraps to 0 (no scrolling).
REQ-022 Codes 7'h0A and 7'h0D SHALL set col to 0 and increment row with the same wrap, with no RAM write.
REQ-023 Code 7'h08 SHALL step the cursor back one position (col-1; at col 0, go to col COLS-1 of row-1) and write BLANK at the new position.
REQ-024 Code 7'h08 at row 0, col 0 SHALL be consumed with no write and no cursor change.
REQ-025 All other codes SHALL be consumed with no write and no cursor change.
REQ-026 Every accepted character SHALL occupy exactly 2 cycles (IDLE accept, then WRITE) before ch_ready returns, even when no write occurs; the maximum rate is one character per 2 cycles.
REQ-027 The cursor SHALL update on the same edge that leaves WRITE.
REQ-028 CLEAR SHALL write BLANK to addresses 0..ROWS*COLS-1 in ascending order, one per cycle, wvram held high throughout: 4800 consecutive writes for the defaults.
REQ-029 After the final clear write, the controller SHALL return to IDLE with cursor 0,0 and wvram low.
REQ-030 cls_req and ch_valid SHALL be ignored during WRITE and CLEAR; they are not queued.
REQ-031 busy SHALL equal (state != IDLE); wvram SHALL never be high in IDLE.

Reset
REQ-032 Asserting clr SHALL immediately force: state IDLE, wvram 0, vram_addr 0, vram_data 0, cursor_row 0, cursor_col 0, busy 0.
REQ-033 Asserting clr mid-CLEAR SHALL abort the clear; no further writes occur.
REQ-034 ch_ready SHALL read 1 while clr is high and cls_req is low.

Verification
REQ-035 Reset, then 'A' (7'h41) offered -> accepted on cycle 1; next cycle wvram=1, addr 0, data 7'h41; cursor becomes 0,1.
REQ-036 Cursor at 2,79, 'B' written -> addr 239; cursor becomes 3,0.
REQ-037 Cursor at 59,79, printable char -> addr 4799; cursor wraps to 0,0.
REQ-038 Cursor at 5,0, 7'h08 -> cursor 4,79 and BLANK written at addr 399; at 0,0, 7'h08 -> no write, cursor unchanged.
REQ-039 cls_req and ch_valid asserted together in IDLE -> character not accepted; 4800 writes of 7'h20 at addr 0..4799; then cursor 0,0 and ch_ready=1.
REQ-040 clr pulsed after 100 clear writes -> wvram drops asynchronously with no further writes; cursor 0,0; the next character writes addr 0.
